// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one RAM port between the instruction-fetch and the
// data-access requesters. Data wins by default; a starvation counter forces
// a fetch grant after STARVE_MAX consecutive data grants while a fetch waits.
// A watchdog aborts a grant that never sees ramready.
//
// Ports
//   CLK, RST                      clock, async active-high reset
//   iREN, iaddr                   fetch request (level) and address
//   dREN, dWEN, daddr, dstore     data request (level), address, write data
//   ihit, iload                   fetch completion pulse, fetch data
//   dhit, dload                   data completion pulse, read data
//   ramREN, ramWEN, ramaddr,
//   ramstore, ramload, ramready   shared RAM port
//   timeout                       one-cycle pulse after an aborted grant
module mem_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        ihit,
  output logic [31:0] iload,
  output logic        dhit,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic        ramready,
  output logic        timeout
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  localparam logic [9:0] WD_LIM     = 10'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, IGNT, DGNT, IDONE, DDONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] store_q, store_d;
  logic        wr_q, wr_d;
  logic [31:0] iload_q, iload_d;
  logic [31:0] dload_q, dload_d;
  logic [3:0]  starve_q, starve_d;
  logic [9:0]  wd_q, wd_d;
  logic        timeout_q, timeout_d;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    store_d   = store_q;
    wr_d      = wr_q;
    iload_d   = iload_q;
    dload_d   = dload_q;
    starve_d  = starve_q;
    wd_d      = wd_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        // Starvation override first, then data priority, then plain fetch.
        if (iREN && (starve_q == STARVE_LIM || !(dREN || dWEN))) begin
          state_d  = IGNT;
          addr_d   = iaddr;
          store_d  = '0;
          wr_d     = 1'b0;
          starve_d = '0;
          wd_d     = '0;
        end else if (dREN || dWEN) begin
          state_d  = DGNT;
          addr_d   = daddr;
          store_d  = dstore;
          wr_d     = dWEN;  // read+write together is a write
          wd_d     = '0;
          if (!iREN)                    starve_d = '0;
          else if (starve_q < STARVE_LIM) starve_d = starve_q + 4'd1;
        end
      end
      IGNT, DGNT: begin
        // ramready beats a watchdog expiry in the same cycle.
        if (ramready) begin
          if (state_q == IGNT) begin
            iload_d = ramload;
            state_d = IDONE;
          end else begin
            if (!wr_q) dload_d = ramload;
            state_d = DDONE;
          end
        end else if (wd_q == WD_LIM) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end else begin
          wd_d = wd_q + 10'd1;
        end
      end
      IDONE, DDONE: state_d = IDLE;
      default:      state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      store_q   <= '0;
      wr_q      <= 1'b0;
      iload_q   <= '0;
      dload_q   <= '0;
      starve_q  <= '0;
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      store_q   <= store_d;
      wr_q      <= wr_d;
      iload_q   <= iload_d;
      dload_q   <= dload_d;
      starve_q  <= starve_d;
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end

  // RAM side is decoded only from flops, so strobes fall as soon as the
  // state register is reset.
  assign ramREN   = (state_q == IGNT) || (state_q == DGNT && !wr_q);
  assign ramWEN   = (state_q == DGNT) && wr_q;
  assign ramaddr  = (state_q == IGNT || state_q == DGNT) ? addr_q : '0;
  assign ramstore = (state_q == DGNT) ? store_q : '0;

  assign ihit    = (state_q == IDONE);
  assign dhit    = (state_q == DDONE);
  assign iload   = iload_q;
  assign dload   = dload_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: requests push expected completions into
// queues, a negedge monitor models the RAM and pops/compares on each hit.
module tb_mem_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore;
  logic        ihit, dhit, ramREN, ramWEN, ramready, timeout;
  logic [31:0] iload, dload, ramaddr, ramstore, ramload;

  mem_arbiter #(.STARVE_MAX(4), .TIMEOUT(8)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .ihit(ihit), .iload(iload), .dhit(dhit), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramready(ramready), .timeout(timeout)
  );

  always #5 CLK = ~CLK;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] data_of(input logic [31:0] a);
    if (a == 32'h40) return 32'hDEADBEEF;
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } dreq_t;

  logic [31:0] iq[$];
  dreq_t       dq[$];
  dreq_t       mon_e;
  logic [31:0] exp_dload = '0;
  int          lat = 0;   // ramready on the lat-th strobe cycle; 0 = never
  int          scnt = 0;

  task automatic push_d(input logic wr, input logic [31:0] a, input logic [31:0] d);
    dreq_t r;
    r.wr = wr; r.addr = a; r.data = d;
    dq.push_back(r);
  endtask

  // RAM model + scoreboard
  always @(negedge CLK) begin
    if (RST) begin
      scnt = 0; ramready = 1'b0; ramload = 32'hBAD0BAD0;
      exp_dload = '0; iq.delete(); dq.delete();
    end else begin
      if (ihit) begin
        if (iq.size() == 0) check("ihit_unexpected", 32'd1, 32'd0);
        else check("iload", iload, iq.pop_front());
      end
      if (dhit) begin
        if (dq.size() == 0) check("dhit_unexpected", 32'd1, 32'd0);
        else begin
          mon_e = dq.pop_front();
          if (!mon_e.wr) exp_dload = mon_e.data;
          check("dload", dload, exp_dload);
        end
      end
      ramready = 1'b0;
      ramload  = 32'hBAD0BAD0;
      if (ramREN || ramWEN) begin
        scnt++;
        if (lat != 0 && scnt == lat) begin
          ramready = 1'b1;
          scnt = 0;
          if (ramWEN) begin
            if (dq.size() == 0) check("wr_unexpected", 32'd1, 32'd0);
            else begin
              check("wr_addr", ramaddr, dq[0].addr);
              check("wr_data", ramstore, dq[0].data);
            end
          end else ramload = data_of(ramaddr);
        end
      end else scnt = 0;
    end
  end

  task automatic chk_zero(input string p);
    check({p, "_ihit"},     32'(ihit), 0);
    check({p, "_dhit"},     32'(dhit), 0);
    check({p, "_timeout"},  32'(timeout), 0);
    check({p, "_ramREN"},   32'(ramREN), 0);
    check({p, "_ramWEN"},   32'(ramWEN), 0);
    check({p, "_ramaddr"},  ramaddr, 0);
    check({p, "_ramstore"}, ramstore, 0);
    check({p, "_iload"},    iload, 0);
    check({p, "_dload"},    dload, 0);
  endtask

  task automatic wait_dhit(input string tag, input int budget);
    int got = 0;
    for (int n = 0; n < budget && got == 0; n++) begin
      @(negedge CLK);
      if (dhit) got = 1;
    end
    check(tag, got, 1);
  endtask

  initial begin
    int dt, it, nw, rounds, nren, n2, tt, got, seen;
    logic prev_wen;
    logic [31:0] wa;
    RST = 1'b1; iREN = 0; dREN = 0; dWEN = 0;
    iaddr = '0; daddr = '0; dstore = '0;
    repeat (2) @(negedge CLK);
    chk_zero("rst");
    #2 RST = 1'b0;
    @(negedge CLK);

    // Lone fetch, latency 3; address change mid-grant must be ignored
    lat = 3; iaddr = 32'h40; iREN = 1; iq.push_back(32'hDEADBEEF);
    @(negedge CLK); check("t1_ren_c1", 32'(ramREN), 1); check("t1_addr_c1", ramaddr, 32'h40);
    iaddr = 32'h44;
    @(negedge CLK); check("t1_addr_held", ramaddr, 32'h40);
    @(negedge CLK); check("t1_ren_c3", 32'(ramREN), 1);
    @(negedge CLK); check("t1_ihit_c4", 32'(ihit), 1); check("t1_ren_c4", 32'(ramREN), 0);
    iREN = 0;
    @(negedge CLK); check("t1_ihit_c5", 32'(ihit), 0); check("t1_ren_c5", 32'(ramREN), 0);

    // Simultaneous fetch and read: data first
    lat = 2; iaddr = 32'h100; daddr = 32'h200; iREN = 1; dREN = 1;
    iq.push_back(data_of(32'h100)); push_d(0, 32'h200, data_of(32'h200));
    dt = -1; it = -1;
    for (int n = 1; n <= 20 && it < 0; n++) begin
      @(negedge CLK);
      if (dhit) begin dt = n; dREN = 0; end
      if (ihit) begin it = n; iREN = 0; end
    end
    check("t2_dhit_cyc", dt, 3);
    check("t2_ihit_cyc", it, 7);

    // Starvation: writes stream continuously, fetch held
    lat = 1; iaddr = 32'h300; iREN = 1; iq.push_back(data_of(32'h300));
    wa = 32'h400; daddr = wa; dstore = 32'hA0000000 | wa; dWEN = 1;
    push_d(1, wa, dstore);
    nw = 0; rounds = 0; prev_wen = 0;
    for (int n = 0; n < 200 && rounds < 2; n++) begin
      @(negedge CLK);
      if (ramWEN && !prev_wen) nw++;
      prev_wen = ramWEN;
      if (dhit) begin
        wa = wa + 4; daddr = wa; dstore = 32'hA0000000 | wa;
        push_d(1, wa, dstore);
      end
      if (ihit) begin
        check($sformatf("t3_writes_r%0d", rounds), nw, 4);
        nw = 0; rounds++;
        if (rounds < 2) begin
          iaddr = 32'h340; iq.push_back(data_of(32'h340));
        end else begin
          iREN = 0; dWEN = 0; void'(dq.pop_back());
        end
      end
    end
    check("t3_rounds", rounds, 2);
    @(negedge CLK);

    // Watchdog: no ramready, then ramready on the last allowed cycle
    lat = 0; iaddr = 32'h500; iREN = 1; iq.push_back(data_of(32'h500));
    nren = 0; seen = 0; got = 0;
    for (int n = 0; n < 40 && seen == 0; n++) begin
      @(negedge CLK);
      if (ramREN) nren++;
      if (ihit) got++;
      if (timeout) begin
        seen = 1; lat = 8;
        check("t4_ren_at_tout", 32'(ramREN), 0);
      end
    end
    check("t4_tout_seen", seen, 1);
    check("t4_ren_cycles", nren, 8);
    check("t4_no_ihit", got, 0);
    n2 = 0; tt = 0; got = 0;
    for (int n = 0; n < 20 && got == 0; n++) begin
      @(negedge CLK);
      if (n == 0) check("t4_regrant", 32'(ramREN), 1);
      if (ramREN) n2++;
      if (timeout) tt++;
      if (ihit) begin got = 1; iREN = 0; end
    end
    check("t4_ihit_after", got, 1);
    check("t4_ren_cycles2", n2, 8);
    check("t4_no_tout2", tt, 0);

    // Read sets dload, then read+write together acts as a write
    lat = 1; daddr = 32'h600; dREN = 1; push_d(0, 32'h600, data_of(32'h600));
    wait_dhit("t5_read_hit", 10);
    dREN = 0;
    @(negedge CLK);
    dREN = 1; dWEN = 1; daddr = 32'h80; dstore = 32'h12345678;
    push_d(1, 32'h80, 32'h12345678);
    @(negedge CLK);
    check("t5_wen", 32'(ramWEN), 1); check("t5_ren", 32'(ramREN), 0);
    check("t5_store", ramstore, 32'h12345678); check("t5_addr", ramaddr, 32'h80);
    wait_dhit("t5_write_hit", 10);
    dREN = 0; dWEN = 0;
    check("t5_dload_kept", dload, data_of(32'h600));
    @(negedge CLK);

    // Async reset in the middle of a write grant
    lat = 0; dWEN = 1; daddr = 32'h90; dstore = 32'h55; push_d(1, 32'h90, 32'h55);
    @(negedge CLK); @(negedge CLK);
    check("t6_wen_before", 32'(ramWEN), 1);
    #1 RST = 1'b1;
    #1 check("t6_wen_async", 32'(ramWEN), 0);
    chk_zero("t6");
    dWEN = 0;
    @(negedge CLK);
    #2 RST = 1'b0;
    @(negedge CLK);
    check("t6_idle_wen", 32'(ramWEN), 0); check("t6_idle_ren", 32'(ramREN), 0);

    // Normal fetch after reset
    lat = 1; iaddr = 32'h700; iREN = 1; iq.push_back(data_of(32'h700));
    got = 0;
    for (int n = 0; n < 10 && got == 0; n++) begin
      @(negedge CLK);
      if (ihit) begin got = 1; iREN = 0; end
    end
    check("t7_ihit", got, 1);
    @(negedge CLK);
    check("end_iq_empty", iq.size(), 0);
    check("end_dq_empty", dq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
